l1d_wb_cache: RTL
=================

# l1d_wb_cache

Parametrised write-back, write-allocate, direct-mapped L1 data cache controller with a valid/ready request port toward the core and a line-burst port toward main memory. It supersedes the fixed-size cache inside the memory subsystem, adding configurable geometry, dirty-line writeback and multi-word refill bursts, and sits between the load/store unit and the main memory model.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, word width; addresses are word-aligned (low log2(DATA_W/8) bits ignored)
- NUM_LINES, 16, lines in the cache (power of two, ≥2)
- WORDS_PER_LINE, 4, words per line (power of two, ≥2)
- CLK  in  1  single clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- REQ_VALID / REQ_READY  in/out  1  core request handshake
- REQ_STORE  in  1  1 = store, 0 = load
- REQ_ADDR  in  ADDR_W  byte address
- REQ_WDATA  in  DATA_W  store data
- RSP_VALID  out  1  one-cycle response pulse (no back-pressure)
- RSP_RDATA  out  DATA_W  load data; store data echoed for stores
- MEM_REQ_VALID / MEM_REQ_READY  out/in  1  memory command handshake
- MEM_REQ_WRITE  out  1  1 = line writeback, 0 = line refill
- MEM_ADDR  out  ADDR_W  line-aligned byte address
- MEM_WVALID / MEM_WREADY  out/in  1  writeback beat handshake
- MEM_WDATA  out  DATA_W  writeback beat
- MEM_RVALID  in  1  refill beat valid (no back-pressure)
- MEM_RDATA  in  DATA_W  refill beat

## Operation
- Address split: word offset (log2 WORDS_PER_LINE), index (log2 NUM_LINES), tag (remainder). Default: offset [3:2], index [7:4], tag [31:8].
- States: IDLE, LOOKUP, WB_REQ, WB_DATA, RF_REQ, RF_DATA.
- IDLE: REQ_READY=1; on REQ_VALID&&REQ_READY capture op/addr/wdata → LOOKUP.
- LOOKUP: hit = valid && tag match. Hit load: RSP_RDATA = word, RSP_VALID next cycle → IDLE. Hit store: write word, set dirty, RSP_VALID next cycle → IDLE. Miss, line dirty → WB_REQ; miss, clean/invalid → RF_REQ.
- WB_REQ: MEM_REQ_VALID=1, WRITE=1, MEM_ADDR = old tag|index; on ready → WB_DATA.
- WB_DATA: WORDS_PER_LINE beats, offset 0 upward, each on MEM_WVALID&&MEM_WREADY; after last → RF_REQ.
- RF_REQ: MEM_REQ_VALID=1, WRITE=0, MEM_ADDR = new tag|index; on ready → RF_DATA.
- RF_DATA: each MEM_RVALID writes next word, offset 0 upward; after last beat set valid, update tag, clear dirty → LOOKUP (now hits).
- Beat counter wraps to 0 after WORDS_PER_LINE-1.

## Timing
- Reset: state IDLE, all valid/dirty bits 0, REQ_READY=0 during reset and 1 on the first cycle after; RSP_VALID, MEM_REQ_VALID, MEM_WVALID, MEM_REQ_WRITE = 0; RSP_RDATA, MEM_ADDR, MEM_WDATA = 0. Data/tag arrays not reset.
- Hit latency: accept at cycle 0, RSP_VALID at cycle 2.
- Miss latency: 2 + command wait + refill beats + 2 (plus writeback when dirty).
- MEM_REQ_VALID, MEM_ADDR, MEM_REQ_WRITE held stable until MEM_REQ_READY; MEM_WDATA stable until MEM_WREADY.
- REQ_READY low outside IDLE; REQ_VALID there is ignored.
- MEM_RVALID outside RF_DATA is ignored.
- Reset mid-transaction: abandon immediately, next cycle IDLE with all lines invalid; partially refilled line never valid. Memory shares RESET.

## Configuration
- L1D_STATS_EN defined: outputs HIT_COUNT and MISS_COUNT (32 bits each, reset 0) increment once per LOOKUP outcome of an accepted request (the post-refill re-LOOKUP is not counted); both saturate at 0xFFFFFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package l1d_pkg: state enum, field-width localparams derived from parameters, addr-split helper functions.
- Sub-module l1d_line_store: tag/valid/dirty arrays plus data array, combinational read, one-word synchronous write, whole-array valid clear on RESET.

## Test plan
- Reset, load 0x100 → MEM_REQ addr 0x100 WRITE=0; feed 0xA0–0xA3 → RSP_RDATA 0xA0; miss count 1.
- Then load 0x10C → RSP_VALID 2 cycles after accept, data 0xA3, no MEM_REQ_VALID.
- Store 0x104 = 0xDEADBEEF, then load 0x204 → writeback 0x100 beats A0, DEADBEEF, A2, A3, then refill at 0x200.
- Hold MEM_REQ_READY low 5 cycles and MEM_WREADY low on beat 1 → command and WDATA held stable, no beat lost.
- Assert RESET during refill beat 2 → next cycle IDLE, MEM_REQ_VALID 0; reload 0x100 misses again.
- With L1D_STATS_EN: 3 misses, 5 hits → HIT_COUNT 5, MISS_COUNT 3.

Source files
------------

// File: rtl/l1d_pkg.sv
// l1d_pkg: controller state encoding plus address-split helpers shared by the
// L1 data cache top and its line store.
package l1d_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB_REQ,
        S_WB_DATA,
        S_RF_REQ,
        S_RF_DATA
    } state_e;

    function automatic int unsigned byte_bits(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int unsigned off_bits(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int unsigned idx_bits(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned addr_w, input int unsigned data_w,
                                             input int unsigned num_lines,
                                             input int unsigned words_per_line);
        return addr_w - byte_bits(data_w) - off_bits(words_per_line) - idx_bits(num_lines);
    endfunction

    // Field of `width` bits starting at bit `lsb`; callers size-cast the result.
    function automatic logic [63:0] addr_field(input logic [63:0] addr, input int unsigned lsb,
                                               input int unsigned width);
        return (addr >> lsb) & ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/l1d_wb_cache_if.sv
// Core-side request/response bus and memory-side line-burst bus of the L1 data cache.
interface l1d_core_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (output req_valid, req_store, req_addr, req_wdata,
                    input  req_ready, rsp_valid, rsp_rdata);
    modport slave  (input  req_valid, req_store, req_addr, req_wdata,
                    output req_ready, rsp_valid, rsp_rdata);
endinterface

interface l1d_mem_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] addr;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req_valid, req_write, addr, wvalid, wdata,
                    input  req_ready, wready, rvalid, rdata);
    modport slave  (input  req_valid, req_write, addr, wvalid, wdata,
                    output req_ready, wready, rvalid, rdata);
endinterface

// File: rtl/l1d_line_store.sv
// l1d_line_store: tag/valid/dirty and data arrays of a direct-mapped cache.
// Combinational read and one-word synchronous write at (idx_i, off_i).
module l1d_line_store
    import l1d_pkg::*;
#(
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned TAG_W          = 24,
    parameter int unsigned DATA_W         = 32,
    localparam int unsigned IDX_W         = idx_bits(NUM_LINES),
    localparam int unsigned OFF_W         = off_bits(WORDS_PER_LINE)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [OFF_W-1:0]  off_i,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              set_dirty_i,
    input  logic              fill_i,
    input  logic [TAG_W-1:0]  fill_tag_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [DATA_W-1:0]    data_q [NUM_LINES][WORDS_PER_LINE];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign rdata_o = data_q[idx_i][off_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (set_dirty_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; the valid bits alone decide whether they mean anything.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            data_q[idx_i][off_i] <= wdata_i;
        end
        if (fill_i) begin
            tag_q[idx_i] <= fill_tag_i;
        end
    end

endmodule

// File: rtl/l1d_wb_cache.sv
// l1d_wb_cache: write-back, write-allocate, direct-mapped L1 data cache controller.
// Define L1D_STATS_EN to add saturating hit_count_o / miss_count_o counters.
module l1d_wb_cache
    import l1d_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    l1d_core_if.slave  core_bus,
    l1d_mem_if.master  mem_bus
`ifdef L1D_STATS_EN
    ,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
`endif
);

    localparam int unsigned BYTE_W  = byte_bits(DATA_W);
    localparam int unsigned OFF_W   = off_bits(WORDS_PER_LINE);
    localparam int unsigned IDX_W   = idx_bits(NUM_LINES);
    localparam int unsigned TAG_W   = tag_bits(ADDR_W, DATA_W, NUM_LINES, WORDS_PER_LINE);
    localparam int unsigned IDX_LSB = BYTE_W + OFF_W;
    localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;
    localparam logic [OFF_W-1:0]   LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);
    localparam logic [IDX_LSB-1:0] LINE_LSBS = '0;

    state_e            state_q, state_d;
    logic              req_store_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              accept, hit, live;

    logic [OFF_W-1:0]  st_off;
    logic              st_valid, st_dirty, st_we, st_set_dirty, st_fill;
    logic [TAG_W-1:0]  st_tag;
    logic [DATA_W-1:0] st_rdata, st_wdata;

    assign req_off = OFF_W'(addr_field(64'(req_addr_q), BYTE_W, OFF_W));
    assign req_idx = IDX_W'(addr_field(64'(req_addr_q), IDX_LSB, IDX_W));
    assign req_tag = TAG_W'(addr_field(64'(req_addr_q), TAG_LSB, TAG_W));

    assign live   = !rst_i;
    assign accept = core_bus.req_valid && core_bus.req_ready;
    assign hit    = st_valid && (st_tag == req_tag);
    // Bursts walk the line with the beat counter; everything else uses the request word.
    assign st_off = (state_q == S_WB_DATA || state_q == S_RF_DATA) ? beat_q : req_off;

    l1d_line_store #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W),
        .DATA_W         (DATA_W)
    ) u_store (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (req_idx),
        .off_i       (st_off),
        .valid_o     (st_valid),
        .dirty_o     (st_dirty),
        .tag_o       (st_tag),
        .rdata_o     (st_rdata),
        .we_i        (st_we),
        .wdata_i     (st_wdata),
        .set_dirty_i (st_set_dirty),
        .fill_i      (st_fill),
        .fill_tag_i  (req_tag)
    );

    assign core_bus.req_ready = live && (state_q == S_IDLE);
    assign core_bus.rsp_valid = live && rsp_valid_q;
    assign core_bus.rsp_rdata = rsp_rdata_q;

    assign mem_bus.req_valid = live && (state_q == S_WB_REQ || state_q == S_RF_REQ);
    assign mem_bus.req_write = live && (state_q == S_WB_REQ);
    assign mem_bus.addr      = !live                ? '0 :
                               (state_q == S_WB_REQ) ? {st_tag, req_idx, LINE_LSBS} :
                               (state_q == S_RF_REQ) ? {req_tag, req_idx, LINE_LSBS} : '0;
    assign mem_bus.wvalid    = live && (state_q == S_WB_DATA);
    assign mem_bus.wdata     = mem_bus.wvalid ? st_rdata : '0;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        st_we        = 1'b0;
        st_wdata     = req_wdata_q;
        st_set_dirty = 1'b0;
        st_fill      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit) begin
                    rsp_valid_d = 1'b1;
                    state_d     = S_IDLE;
                    if (req_store_q) begin
                        st_we        = 1'b1;
                        st_set_dirty = 1'b1;
                        rsp_rdata_d  = req_wdata_q;
                    end else begin
                        rsp_rdata_d  = st_rdata;
                    end
                end else if (st_valid && st_dirty) begin
                    state_d = S_WB_REQ;
                end else begin
                    state_d = S_RF_REQ;
                end
            end
            S_WB_REQ: begin
                if (mem_bus.req_ready) state_d = S_WB_DATA;
            end
            S_WB_DATA: begin
                if (mem_bus.wready) begin
                    beat_d = beat_q + OFF_W'(1);
                    if (beat_q == LAST_BEAT) state_d = S_RF_REQ;
                end
            end
            S_RF_REQ: begin
                if (mem_bus.req_ready) state_d = S_RF_DATA;
            end
            S_RF_DATA: begin
                if (mem_bus.rvalid) begin
                    st_we    = 1'b1;
                    st_wdata = mem_bus.rdata;
                    beat_d   = beat_q + OFF_W'(1);
                    // Line only becomes valid once the final beat lands.
                    if (beat_q == LAST_BEAT) begin
                        st_fill = 1'b1;
                        state_d = S_LOOKUP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            req_store_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (accept) begin
                req_store_q <= core_bus.req_store;
                req_addr_q  <= core_bus.req_addr;
                req_wdata_q <= core_bus.req_wdata;
            end
        end
    end

`ifdef L1D_STATS_EN
    logic        relook_q;
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // relook_q marks the LOOKUP that follows a refill so it is not counted twice.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            relook_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (accept)       relook_q <= 1'b0;
            else if (st_fill) relook_q <= 1'b1;
            if (state_q == S_LOOKUP && !relook_q) begin
                if (hit) hit_cnt_q  <= hit_cnt_q  + {31'd0, ~&hit_cnt_q};
                else     miss_cnt_q <= miss_cnt_q + {31'd0, ~&miss_cnt_q};
            end
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

endmodule
